// File: rtl/bootram_pkg.sv
// bootram_pkg: shared constants and FSM encoding for the boot RAM loader
package bootram_pkg;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int CS_HIGH_MULT = 4;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, FINISH} state_t;
endpackage

// File: rtl/spi_shift8.sv
// spi_shift8: SPI mode-0 byte engine, MSB first; a start on the final falling edge chains bytes gaplessly
module spi_shift8 #(
  parameter int SCK_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx
);
  localparam int CW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;
  logic          active;
  logic [CW-1:0] cnt;
  logic [2:0]    bits;
  logic [7:0]    sr;
  logic          tick;
  assign tick = active && cnt == CW'(SCK_HALF - 1);
  assign done = tick && sck && bits == 3'd7;
  always_ff @(posedge clk)
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      bits   <= '0;
      sr     <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
      rx     <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      bits   <= '0;
      sr     <= {tx[6:0], 1'b0};
      mosi   <= tx[7];
      sck    <= 1'b0;
    end else if (done) begin
      active <= 1'b0;
      cnt    <= '0;
      sck    <= 1'b0;
      mosi   <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sck <= !sck;
      if (!sck) rx <= {rx[6:0], miso};
      else begin
        bits <= bits + 3'd1;
        mosi <= sr[7];
        sr   <= {sr[6:0], 1'b0};
      end
    end else if (active) cnt <= cnt + CW'(1);
endmodule

// File: rtl/bootram_loader.sv
// bootram_loader: copies LOAD_LEN bytes from SPI flash into the boot RAM through its NORA write port
module bootram_loader
  import bootram_pkg::*;
#(
  parameter int          BITDEPTH   = 9,
  parameter int          LOAD_LEN   = 512,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int          SCK_HALF   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                spi_csn_o,
  output logic                spi_sck_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  output logic [BITDEPTH-1:0] slv_addr_o,
  output logic [7:0]          slv_datawr_o,
  output logic                slv_datawr_valid_o,
  output logic                slv_req_o,
  output logic                slv_rwn_o
);
  localparam int FW = $clog2(CS_HIGH_MULT * SCK_HALF);
  state_t              state, nxt;
  logic [BITDEPTH-1:0] cnt;
  logic [1:0]          acnt;
  logic [FW-1:0]       fcnt;
  logic [7:0]          byte_q;
  logic                sh_start, sh_done, last;
  logic [7:0]          sh_tx, sh_rx;
  spi_shift8 #(.SCK_HALF(SCK_HALF)) u_shift (
    .clk  (clk),
    .reset(reset),
    .start(sh_start),
    .tx   (sh_tx),
    .miso (spi_miso_i),
    .sck  (spi_sck_o),
    .mosi (spi_mosi_o),
    .done (sh_done),
    .rx   (sh_rx)
  );
  assign last = cnt == BITDEPTH'(LOAD_LEN - 1);
  always_comb begin
    nxt      = state;
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    case (state)
      IDLE: if (start_i) begin
        nxt      = CMD;
        sh_start = 1'b1;
        sh_tx    = SPI_CMD_READ;
      end
      CMD: if (sh_done) begin
        nxt      = ADDR;
        sh_start = 1'b1;
        sh_tx    = FLASH_ADDR[23:16];
      end
      ADDR: if (sh_done) begin
        nxt      = acnt == 2'd2 ? DATA : ADDR;
        sh_start = 1'b1;
        sh_tx    = acnt == 2'd0 ? FLASH_ADDR[15:8] : acnt == 2'd1 ? FLASH_ADDR[7:0] : 8'h00;
      end
      DATA: if (sh_done) nxt = WRITE;
      WRITE: begin
        nxt      = last ? FINISH : DATA;
        sh_start = !last;
      end
      FINISH: if (fcnt == FW'(CS_HIGH_MULT * SCK_HALF - 1)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acnt   <= '0;
      fcnt   <= '0;
      byte_q <= '0;
      done_o <= 1'b0;
    end else begin
      state <= nxt;
      acnt  <= state != ADDR ? 2'd0 : sh_done ? acnt + 2'd1 : acnt;
      fcnt  <= state == FINISH ? fcnt + FW'(1) : '0;
      if (state == IDLE && start_i) begin
        cnt    <= '0;
        done_o <= 1'b0;
      end
      if (state == DATA && sh_done) byte_q <= sh_rx;
      if (state == WRITE) cnt <= cnt + BITDEPTH'(1);
      if (state == FINISH && nxt == IDLE) done_o <= 1'b1;
    end
  assign busy_o             = state != IDLE;
  assign spi_csn_o          = state == IDLE || state == FINISH;
  assign slv_req_o          = state == WRITE;
  assign slv_datawr_valid_o = state == WRITE;
  assign slv_rwn_o          = state != WRITE;
  assign slv_addr_o         = cnt;
  assign slv_datawr_o       = byte_q;
endmodule

// File: tb/tb_bootram_loader.sv
// tb_bootram_loader: directed bench with a flash model, three loader configurations and bus/SPI timing monitors
module tb_bootram_loader;
  logic             clk = 1'b0;
  logic [2:0]       rst, start, busy, done, csn, sck, mosi, valid, req, rwn;
  logic [2:0][8:0]  addr;
  logic [2:0][7:0]  data;
  int               n_cmp = 0, n_bad = 0, fin;
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_byte(input logic [23:0] base, input int k);
    logic [31:0] kk = k;
    return (base[7:0] + kk[7:0]) ^ 8'h5A;
  endfunction
  function automatic logic fbit(input logic [31:0] r, input int n);
    logic [7:0] v = exp_byte(r[23:0], n / 8);
    return v[7 - n % 8];
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle(input int g, input int limit, input string tag);
    for (int i = 0; i < limit && busy[g]; i++) @(negedge clk);
    check(tag, {31'h0, busy[g]}, 0);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int          H    = g == 0 ? 2 : g == 1 ? 1 : 3;
    localparam int          LEN  = g == 0 ? 512 : 4;
    localparam logic [23:0] BASE = g == 0 ? 24'h000000 : 24'h012340;
    logic        miso = 1'b0, psck = 1'b0, pmosi = 1'b0, pbusy = 1'b0, pv = 1'b0;
    logic [31:0] rx32 = '0;
    logic [7:0]  got [4];
    int          bc = 0, cyc = 0, last_rise = 0, last_mosi = 0, wr_cnt = 0, busy_len = 0, last_len = 0;
    int          bad_wr = 0, bad_strobe = 0, bad_sck = 0, bad_mosi = 0;
    bootram_loader #(.BITDEPTH(9), .LOAD_LEN(LEN), .FLASH_ADDR(BASE), .SCK_HALF(H)) u_dut (
      .clk               (clk),
      .reset             (rst[g]),
      .start_i           (start[g]),
      .busy_o            (busy[g]),
      .done_o            (done[g]),
      .spi_csn_o         (csn[g]),
      .spi_sck_o         (sck[g]),
      .spi_mosi_o        (mosi[g]),
      .spi_miso_i        (miso),
      .slv_addr_o        (addr[g]),
      .slv_datawr_o      (data[g]),
      .slv_datawr_valid_o(valid[g]),
      .slv_req_o         (req[g]),
      .slv_rwn_o         (rwn[g])
    );
    always @(negedge clk) begin
      cyc   <= cyc + 1;
      psck  <= sck[g];
      pmosi <= mosi[g];
      pv    <= valid[g];
      pbusy <= busy[g];
      if (csn[g]) bc <= 0;
      else if (!psck && sck[g]) begin
        if (bc < 32) rx32 <= {rx32[30:0], mosi[g]};
        bc <= bc + 1;
        if (bc > 0 && cyc - last_rise != ((bc > 32 && (bc - 32) % 8 == 0) ? 2 * H + 1 : 2 * H))
          bad_sck <= bad_sck + 1;
        if (cyc - last_mosi < H || (bc >= 32 && mosi[g])) bad_mosi <= bad_mosi + 1;
        last_rise <= cyc;
      end else if (psck && !sck[g]) begin
        if (cyc - last_rise != H) bad_sck <= bad_sck + 1;
        if (bc >= 32) miso <= fbit(rx32, bc - 32);
      end
      if (mosi[g] != pmosi) begin
        last_mosi <= cyc;
        if (sck[g]) bad_mosi <= bad_mosi + 1;
      end
      if (busy[g] && !pbusy) begin
        wr_cnt   <= 0;
        busy_len <= 1;
      end else if (busy[g]) busy_len <= busy_len + 1;
      if (!busy[g] && pbusy && !rst[g]) last_len <= busy_len;
      if (valid[g]) begin
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt < 4) got[wr_cnt[1:0]] <= data[g];
        if (addr[g] != 9'(wr_cnt) || data[g] != exp_byte(BASE, wr_cnt)) bad_wr <= bad_wr + 1;
      end
      if ((pv && valid[g]) || req[g] != valid[g] || rwn[g] == valid[g]) bad_strobe <= bad_strobe + 1;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst   = '1;
    start = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), {31'h0, busy[i]}, 0);
      check($sformatf("rst_done%0d", i), {31'h0, done[i]}, 0);
      check($sformatf("rst_spi%0d", i), {29'h0, csn[i], sck[i], mosi[i]}, 32'h4);
      check($sformatf("rst_slv%0d", i), {12'h0, req[i], valid[i], rwn[i], addr[i], data[i]}, {12'h0, 3'b001, 17'h0});
    end
    rst = '0;
    @(negedge clk);
    start[2:1] = 2'b11;
    @(negedge clk);
    start = '0;
    check("go_h1", {29'h0, busy[1], csn[1], done[1]}, 32'h4);
    check("go_h3", {29'h0, busy[2], csn[2], done[2]}, 32'h4);
    wait_idle(2, 1000, "idle_h3");
    wait_idle(1, 10, "idle_h1");
    repeat (2) @(negedge clk);
    check("h1_cmd", g_dut[1].rx32, 32'h03012340);
    check("h1_data", {g_dut[1].got[0], g_dut[1].got[1], g_dut[1].got[2], g_dut[1].got[3]}, 32'h1A1B1819);
    check("h1_wrs", g_dut[1].wr_cnt, 4);
    check("h1_bus", g_dut[1].bad_wr + g_dut[1].bad_strobe, 0);
    check("h1_sck", g_dut[1].bad_sck, 0);
    check("h1_mosi", g_dut[1].bad_mosi, 0);
    check("h1_lat", g_dut[1].last_len, 136);
    check("h1_end", {29'h0, done[1], busy[1], csn[1]}, 32'h5);
    check("h3_cmd", g_dut[2].rx32, 32'h03012340);
    check("h3_data", {g_dut[2].got[0], g_dut[2].got[1], g_dut[2].got[2], g_dut[2].got[3]}, 32'h1A1B1819);
    check("h3_wrs", g_dut[2].wr_cnt, 4);
    check("h3_bus", g_dut[2].bad_wr + g_dut[2].bad_strobe, 0);
    check("h3_sck", g_dut[2].bad_sck, 0);
    check("h3_mosi", g_dut[2].bad_mosi, 0);
    check("h3_lat", g_dut[2].last_len, 400);
    check("h3_end", {29'h0, done[2], busy[2], csn[2]}, 32'h5);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 5000 && !(valid[0] && addr[0] == 9'd100); i++) @(negedge clk);
    check("w100", {22'h0, valid[0], addr[0]}, {22'h0, 1'b1, 9'd100});
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_spi", {29'h0, csn[0], sck[0], mosi[0]}, 32'h4);
    check("mid_rst_ctl", {30'h0, busy[0], done[0]}, 32'h0);
    check("mid_rst_slv", {29'h0, req[0], valid[0], rwn[0]}, 32'h1);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_rst_nowr", g_dut[0].wr_cnt, 101);
    check("mid_rst_idle", {31'h0, busy[0]}, 0);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("load1_go", {30'h0, busy[0], done[0]}, 32'h2);
    repeat (49) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 2000 && !valid[0]; i++) @(negedge clk);
    check("load1_first", {14'h0, valid[0], addr[0], data[0]}, {14'h0, 1'b1, 9'd0, 8'h5A});
    fin = 0;
    for (int i = 0; i < 20000 && fin < 8; i++) begin
      @(negedge clk);
      fin = (busy[0] && csn[0]) ? fin + 1 : 0;
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("fin_exit", {29'h0, busy[0], done[0], csn[0]}, 32'h3);
    repeat (20) @(negedge clk);
    check("fin_ignored", {30'h0, busy[0], done[0]}, 32'h1);
    check("load1_wrs", g_dut[0].wr_cnt, 512);
    check("load1_cmd", g_dut[0].rx32, 32'h03000000);
    check("load1_lat", g_dut[0].last_len, 17032);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("load2_go", {29'h0, busy[0], done[0], csn[0]}, 32'h4);
    wait_idle(0, 20000, "load2_idle");
    repeat (3) @(negedge clk);
    check("load2_wrs", g_dut[0].wr_cnt, 512);
    check("load2_end", {29'h0, done[0], busy[0], csn[0]}, 32'h5);
    check("load2_lat", g_dut[0].last_len, 17032);
    check("load2_cmd", g_dut[0].rx32, 32'h03000000);
    check("main_bus", g_dut[0].bad_wr + g_dut[0].bad_strobe, 0);
    check("main_sck", g_dut[0].bad_sck, 0);
    check("main_mosi", g_dut[0].bad_mosi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bootram_loader.md
Name: bootram_loader

Overview:
Power-up loader that copies a block of SPI flash into the internal boot RAM before the CPU is released.
- Issues a standard SPI READ (0x03) at a fixed flash address.
- Shifts in LOAD_LEN bytes and writes each into the boot RAM through its NORA slave write port: addr, data, req, rwn, datawr_valid.
- Sits directly upstream of the boot RAM. The system reset controller holds the CPU while busy_o=1.

Parameters:
BITDEPTH, 9, boot RAM address width; RAM holds 2**BITDEPTH bytes.
LOAD_LEN, 512, number of bytes copied; range 1..2**BITDEPTH.
FLASH_ADDR, 24'h000000, 24-bit flash start address sent after the command.
SCK_HALF, 2, SPI SCK half-period in clk cycles; must be >= 1.

Ports:
clk  in  1  system clock (48 MHz)
reset  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse that begins a load; ignored while busy_o=1
busy_o  out  1  high from the cycle after an accepted start until the cycle FINISH exits
done_o  out  1  sticky high after a completed load; cleared by reset or an accepted start
spi_csn_o  out  1  flash chip select, active low
spi_sck_o  out  1  SPI clock, mode 0
spi_mosi_o  out  1  SPI data to flash, MSB first
spi_miso_i  in  1  SPI data from flash
slv_addr_o  out  BITDEPTH  boot RAM byte address
slv_datawr_o  out  8  write data
slv_datawr_valid_o  out  1  write data valid strobe
slv_req_o  out  1  slave request (chip select)
slv_rwn_o  out  1  read=1, write=0

Behaviour:
- Reset values: busy_o=0, done_o=0, spi_csn_o=1, spi_sck_o=0, spi_mosi_o=0, slv_req_o=0, slv_datawr_valid_o=0, slv_rwn_o=1, slv_addr_o=0, slv_datawr_o=0. Byte counter=0, state=IDLE.
- Reset mid-load: all of the above apply on the next edge. Any partial byte is discarded, and no write strobe is issued in the reset cycle.
- States: IDLE -> CMD -> ADDR -> DATA <-> WRITE -> FINISH -> IDLE.
- IDLE: on start_i=1, load the shifter with 0x03 and clear the counter and done_o. Next cycle: state CMD, spi_csn_o=0, busy_o=1.
- SPI timing (mode 0):
  - sck toggles every SCK_HALF clk cycles, starting low.
  - mosi is updated while sck is low, at least SCK_HALF cycles before the rising edge.
  - miso is sampled in the clk cycle sck goes 0->1.
  - One bit = 2*SCK_HALF clk cycles.
- CMD: 8 bits of 0x03. ADDR: 24 bits of FLASH_ADDR, MSB first. mosi=0 during DATA.
- DATA: shift in 8 bits MSB first. After the 8th rising-edge sample, sck returns low after its half-period, then go to WRITE.
- WRITE: exactly one clk cycle with slv_req_o=1, slv_rwn_o=0, slv_datawr_valid_o=1, slv_addr_o=counter, slv_datawr_o=byte.
  - Next cycle all three strobes return to idle values and the counter increments.
  - If the written address was LOAD_LEN-1, go to FINISH; otherwise go to DATA.
  - sck stays low during WRITE. The next byte's first rising edge occurs no earlier than SCK_HALF cycles after WRITE.
- FINISH: spi_csn_o=1 and hold for 4*SCK_HALF cycles (CS-high time), then IDLE. busy_o=0 and done_o=1 in the same cycle.
- Address arithmetic: the counter is BITDEPTH bits wide. Comparison is against LOAD_LEN-1, so LOAD_LEN=2**BITDEPTH ends at all-ones with no wrap write.
- start_i while busy: ignored, with no effect on counter or state.
- start_i in the cycle FINISH exits: ignored. It is accepted only in IDLE.
- slv_rwn_o=1 in every cycle except WRITE, so the loader never causes a RAM write outside WRITE.
- Latency for LOAD_LEN=N: (32 + 8N)·2·SCK_HALF + N + 4·SCK_HALF + small constant (<=4) cycles. The bench checks the exact value fixed by RTL review.

Decomposition:
- Package bootram_pkg:
  - SPI_CMD_READ = 8'h03.
  - State encoding typedef (IDLE, CMD, ADDR, DATA, WRITE, FINISH).
  - CS_HIGH_MULT = 4.
- Sub-module spi_shift8: an 8-bit SPI-mode-0 bit engine.
  - Inputs: SCK_HALF divider, load/start, tx byte.
  - Outputs: sck, mosi, rx byte, byte_done pulse.
  - The loader sequences it for 1 CMD byte, 3 ADDR bytes and N DATA bytes.

Test Plan:
1. Bench setup: SPI flash model with mem[a] = a[7:0] ^ 8'h5A. Checks below refer to this model.
2. Reset, pulse start, LOAD_LEN=512, FLASH_ADDR=0:
   - flash sees 0x03,00,00,00;
   - exactly 512 write strobes, addresses 0..511, data (a^0x5A);
   - done_o=1, busy_o=0, spi_csn_o=1 at the end.
3. FLASH_ADDR=24'h012340, LOAD_LEN=4:
   - flash sees address bytes 01,23,40;
   - RAM addr 0..3 receive 0x1A,0x1B,0x18,0x19.
4. Timing with SCK_HALF=1 and SCK_HALF=3:
   - measured sck period = 2·SCK_HALF;
   - mosi is stable at every rising edge;
   - each slv_datawr_valid_o pulse lasts exactly 1 cycle, with slv_rwn_o=0 only in that cycle.
5. Reset asserted after byte 100's write:
   - next cycle csn=1, sck=0, busy=0, done=0, slv_req=0;
   - no further writes;
   - a fresh start reloads from addr 0.
6. start_i pulsed at cycle 50 mid-load and again in the FINISH exit cycle: both are ignored and the write count stays 512. A subsequent start in IDLE clears done_o and starts a second identical load.
